// File: rtl/n64_cic_phy_if.sv
// Command-push and received-word-pop handshakes between a host and the CIC PHY.
interface n64_cic_phy_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [WIDTH-1:0] cmd_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [WIDTH-1:0] rx_data;

    modport master (
        output cmd_valid, cmd_dir, cmd_data, rx_ready,
        input  cmd_ready, rx_valid, rx_data
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_data, rx_ready,
        output cmd_ready, rx_valid, rx_data
    );
endinterface

// File: rtl/n64_cic_phy.sv
// Bit-level PHY for the N64 CIC serial link: synchronizes the PIF lines, shifts
// queued command words out on the open-drain data pin, and collects received words.
module n64_cic_phy #(
    parameter int SYNC_STAGES    = 2,
    parameter int WIDTH          = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         n64_reset,
    input  logic         n64_cic_clk,
    inout  wire          n64_cic_dq,
    n64_cic_phy_if.slave bus,
    output logic         busy,
    output logic [2:0]   lines,
    output logic [2:0]   flags,
    input  logic [2:0]   flags_clear
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = PW - 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TX_FALL = 2'd1,
        TX_RISE = 2'd2,
        RX_RISE = 2'd3
    } state_e;

    // Full when the wrap bits differ and the index bits match.
    function automatic logic fifo_full(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
        return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    endfunction

    logic [SYNC_STAGES-1:0] rst_sync_q, clk_sync_q, dq_sync_q;
    logic                   clk_dly_q;
    logic                   rst_low_s, fall_s, rise_s, dq_s;

    logic [WIDTH:0]         cmd_mem_q [FIFO_DEPTH];
    logic [PW-1:0]          cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
    logic                   cmd_empty_s, cmd_full_s, cmd_push_s, cmd_pop_s;
    logic [WIDTH:0]         cmd_head_s;

    logic [WIDTH-1:0]       rx_mem_q [FIFO_DEPTH];
    logic [PW-1:0]          rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic                   rx_empty_s, rx_full_s, rx_pop_s, rx_push_s, rx_keep_s, rx_ovf_s;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       shift_q, shift_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   dq_out_q, dq_out_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   tmo_hit_s;
    logic [2:0]             flags_q, flags_d;

    // Synchronizer chains for the PIF lines plus the cic_clk edge-detect delay flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            rst_sync_q <= '1;
            clk_sync_q <= '1;
            dq_sync_q  <= '1;
            clk_dly_q  <= 1'b1;
        end else begin
            rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], n64_reset};
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], n64_cic_clk};
            dq_sync_q  <= {dq_sync_q[SYNC_STAGES-2:0], n64_cic_dq};
            clk_dly_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign rst_low_s = ~rst_sync_q[SYNC_STAGES-1];
    assign fall_s    = clk_dly_q & ~clk_sync_q[SYNC_STAGES-1];
    assign rise_s    = ~clk_dly_q & clk_sync_q[SYNC_STAGES-1];
    assign dq_s      = dq_sync_q[SYNC_STAGES-1];

    assign cmd_empty_s = (cmd_wp_q == cmd_rp_q);
    assign cmd_full_s  = fifo_full(cmd_wp_q, cmd_rp_q);
    assign cmd_push_s  = bus.cmd_valid & ~cmd_full_s;
    assign cmd_head_s  = cmd_mem_q[cmd_rp_q[AW-1:0]];

    // A pop that coincides with a push into a full RX FIFO frees the slot first.
    assign rx_empty_s = (rx_wp_q == rx_rp_q);
    assign rx_full_s  = fifo_full(rx_wp_q, rx_rp_q);
    assign rx_pop_s   = bus.rx_ready & ~rx_empty_s;
    assign rx_keep_s  = rx_push_s & (~rx_full_s | rx_pop_s);
    assign rx_ovf_s   = rx_push_s & rx_full_s & ~rx_pop_s;

    // Next-state pointers for both FIFOs; a low N64 reset flushes them.
    always_comb begin
        cmd_wp_d = cmd_wp_q;
        cmd_rp_d = cmd_rp_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        if (rst_low_s) begin
            cmd_wp_d = '0;
            cmd_rp_d = '0;
            rx_wp_d  = '0;
            rx_rp_d  = '0;
        end else begin
            cmd_wp_d = cmd_push_s ? (cmd_wp_q + PTR_ONE) : cmd_wp_q;
            cmd_rp_d = cmd_pop_s  ? (cmd_rp_q + PTR_ONE) : cmd_rp_q;
            rx_wp_d  = rx_keep_s  ? (rx_wp_q + PTR_ONE)  : rx_wp_q;
            rx_rp_d  = rx_pop_s   ? (rx_rp_q + PTR_ONE)  : rx_rp_q;
        end
    end

    // FIFO storage writes (contents need no reset; the pointers define validity).
    always_ff @(posedge clk) begin
        if (cmd_push_s && !rst_low_s) begin
            cmd_mem_q[cmd_wp_q[AW-1:0]] <= {bus.cmd_dir, bus.cmd_data};
        end
        if (rx_keep_s) begin
            rx_mem_q[rx_wp_q[AW-1:0]] <= shift_d;
        end
    end

    // Engine next-state: N64 reset abort beats timeout abort beats normal shifting.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        dq_out_d  = dq_out_q;
        tmo_d     = tmo_q;
        cmd_pop_s = 1'b0;
        rx_push_s = 1'b0;
        tmo_hit_s = 1'b0;
        if (state_q == IDLE || fall_s || rise_s) begin
            tmo_d = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = tmo_q;
        end

        if (rst_low_s) begin
            state_d  = IDLE;
            dq_out_d = 1'b1;
            cnt_d    = '0;
            tmo_d    = '0;
        end else if (TIMEOUT_CYCLES != 0 && state_q != IDLE && tmo_q == TMO_LIMIT) begin
            tmo_hit_s = 1'b1;
            state_d   = IDLE;
            dq_out_d  = 1'b1;
            cnt_d     = '0;
            tmo_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!cmd_empty_s) begin
                        cmd_pop_s = 1'b1;
                        shift_d   = cmd_head_s[WIDTH-1:0];
                        cnt_d     = '0;
                        state_d   = cmd_head_s[WIDTH] ? TX_FALL : RX_RISE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                TX_FALL: begin
                    if (fall_s) begin
                        dq_out_d = shift_q[WIDTH-1];
                        shift_d  = shift_q << 1;
                        state_d  = TX_RISE;
                    end else begin
                        state_d = TX_FALL;
                    end
                end
                TX_RISE: begin
                    if (rise_s) begin
                        dq_out_d = 1'b1;
                        cnt_d    = cnt_q + CW'(1);
                        state_d  = (cnt_d == CNT_LAST) ? IDLE : TX_FALL;
                    end else begin
                        state_d = TX_RISE;
                    end
                end
                RX_RISE: begin
                    if (rise_s) begin
                        shift_d    = shift_q << 1;
                        shift_d[0] = dq_s;
                        cnt_d      = cnt_q + CW'(1);
                        if (cnt_d == CNT_LAST) begin
                            rx_push_s = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            state_d = RX_RISE;
                        end
                    end else begin
                        state_d = RX_RISE;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    dq_out_d = 1'b1;
                end
            endcase
        end
    end

    // Sticky flags: a set condition in the same cycle wins over its clear.
    always_comb begin
        flags_d = (flags_q & ~flags_clear) | {tmo_hit_s, rx_ovf_s, rst_low_s};
    end

    // Engine, FIFO pointer and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            dq_out_q <= 1'b1;
            tmo_q    <= '0;
            flags_q  <= 3'b000;
            cmd_wp_q <= '0;
            cmd_rp_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            dq_out_q <= dq_out_d;
            tmo_q    <= tmo_d;
            flags_q  <= flags_d;
            cmd_wp_q <= cmd_wp_d;
            cmd_rp_q <= cmd_rp_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
        end
    end

    assign n64_cic_dq    = dq_out_q ? 1'bz : 1'b0;
    assign bus.cmd_ready = ~cmd_full_s;
    assign bus.rx_valid  = ~rx_empty_s;
    assign bus.rx_data   = rx_mem_q[rx_rp_q[AW-1:0]];
    assign busy          = (state_q != IDLE) | ~cmd_empty_s;
    assign lines         = {rst_sync_q[SYNC_STAGES-1], clk_sync_q[SYNC_STAGES-1], dq_sync_q[SYNC_STAGES-1]};
    assign flags         = flags_q;
endmodule

// File: doc/n64_cic_phy.md
N64_CIC_PHY -- requirements
Module: n64_cic_phy

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for n64_reset/n64_cic_clk/n64_cic_dq, legal range >=2.
REQ-002 SHALL have parameter WIDTH, default 4, bits per command word (nibble protocol), legal range 1..32.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries in each of the command FIFO and the RX FIFO, power of 2, >=2.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 0, clk cycles without a cic_clk edge before a busy engine aborts; 0 disables the timeout.
REQ-005 clk  input  1  system clock; the block has one clock, and all logic is in this domain.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 n64_reset  input  1  asynchronous N64 reset line, active low.
REQ-008 n64_cic_clk  input  1  asynchronous CIC bit clock from the PIF.
REQ-009 n64_cic_dq  inout  1  open-drain data line; driven 0 when dq_out=0, else high-Z.
REQ-010 cmd_valid/cmd_ready  input/output  1/1  command push handshake; a push occurs when both are high on a clk edge.
REQ-011 cmd_dir  input  1  1 = transmit to PIF, 0 = receive from PIF.
REQ-012 cmd_data  input  WIDTH  transmit bits, MSB first; ignored when cmd_dir=0.
REQ-013 rx_valid/rx_ready  output/input  1/1  received-word pop handshake; a pop occurs when both are high.
REQ-014 rx_data  output  WIDTH  head of the RX FIFO; first received bit is in the MSB.
REQ-015 busy  output  1  high when the engine is not IDLE or the command FIFO is non-empty.
REQ-016 lines  output  3  {cic_reset, cic_clk, cic_dq}, i.e. the final synchronizer stages.
REQ-017 flags  output  3  sticky flags {timeout, rx_overflow, reset_event}.
REQ-018 flags_clear  input  3  per-bit clear of flags; a set condition in the same cycle wins over the clear.

Function
REQ-019 Each asynchronous input SHALL pass through SYNC_STAGES flops; a falling or rising edge SHALL be detected by comparing the last stage with one additional delay flop.
REQ-020 The engine states SHALL be IDLE, TX_FALL, TX_RISE and RX_RISE.
REQ-021 IDLE SHALL pop the command FIFO head when it is non-empty and the synchronized reset is high, load the shift register and clear the bit counter, then go to TX_FALL (dir=1) or RX_RISE (dir=0).
REQ-022 TX_FALL, on a detected falling edge: dq_out SHALL take the shift MSB, the register SHALL shift left, and the state SHALL go to TX_RISE.
REQ-023 TX_RISE, on a detected rising edge: dq_out SHALL become 1 (released), and the counter SHALL increment; at WIDTH the state SHALL go to IDLE, otherwise back to TX_FALL.
REQ-024 RX_RISE, on a detected rising edge: the synchronized dq SHALL shift into the LSB; after WIDTH bits the word SHALL be pushed to the RX FIFO and the state SHALL go to IDLE.
REQ-025 dq_out SHALL be registered and SHALL change on the clk edge following the cycle of the synchronized edge detect; dq_out SHALL be 1 in every state except TX_RISE.
REQ-026 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never exceed WIDTH.
REQ-027 cmd_ready SHALL equal not-full; a push and a pop in the same cycle SHALL both take effect; a push while full SHALL be impossible.
REQ-028 When the RX FIFO is full at the moment of a push, the word SHALL be dropped and rx_overflow SHALL be set; a simultaneous pop by rx_ready SHALL free space first, so the word is then kept.
REQ-029 FIFO pointers SHALL be $clog2(FIFO_DEPTH)+1 bits, wrapping modulo 2*FIFO_DEPTH; full/empty SHALL be decided by MSB compare.
REQ-030 The timeout counter SHALL reset on any cic_clk edge or in IDLE; when TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, the engine SHALL go to IDLE, set dq_out=1, discard the partial word and set timeout.
REQ-031 A synchronized reset low SHALL, in that cycle, flush both FIFOs, abort the engine to IDLE, set dq_out=1 and set reset_event (level-held); no command SHALL start while it is low.

Reset
REQ-032 On reset the outputs SHALL be: dq_out=1, state IDLE, both FIFOs empty, cmd_ready=1, rx_valid=0, busy=0, flags=0, counters 0, and synchronizer flops 1 (lines=3'b111).
REQ-033 reset SHALL take priority over all other events, including flags set conditions.

Verification
REQ-034 TX: push dir=1 data=4'b1010, toggle cic_clk 4 times -> pin low only during the bit-1 and bit-3 low phases, released after each rising edge; busy=0 after the 4th rising edge.
REQ-035 RX: push dir=0, drive dq 0,1,1,0 sampled on rising edges -> rx_valid=1, rx_data=4'b0110; pop clears rx_valid.
REQ-036 Overflow: with FIFO_DEPTH=4, receive 5 words with rx_ready=0 -> 4 words kept in order, rx_overflow=1; repeat with rx_ready=1 on the 5th push cycle -> no overflow.
REQ-037 Timeout: TIMEOUT_CYCLES=100, start TX, stop cic_clk after bit 1 low -> abort at cycle 100, pin released, timeout=1, next command starts cleanly.
REQ-038 Mid-transfer reset: drop n64_reset during TX bit 2 with 3 commands queued -> pin released within SYNC_STAGES+2 clk, FIFOs empty, reset_event=1; flags_clear=3'b001 while held low keeps reset_event=1.
